// File: rtl/mem_arb_pkg.sv
// Shared definitions for the toggle-handshake memory arbiter: default sizes and FSM states.
package mem_arb_pkg;

    localparam int DEF_NPORT = 2;
    localparam int DEF_AW    = 25;
    localparam int DEF_DW    = 32;
    localparam int DEF_BW    = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        RDATA
    } arb_state_t;

endpackage

// File: rtl/mem_port_slot.sv
// One-entry command latch for a single CPU-side port; busy is simply "slot full".
module mem_port_slot
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW,
    parameter int BW = DEF_BW
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            rd,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   din,
    input  logic [DW/8-1:0] be,
    input  logic [BW-1:0]   burst,
    input  logic            free,
    output logic            full,
    output logic            cmd_wr,
    output logic [AW-1:0]   cmd_addr,
    output logic [DW-1:0]   cmd_din,
    output logic [DW/8-1:0] cmd_be,
    output logic [BW-1:0]   cmd_burst
);

    logic accept;

    assign accept = (rd | we) & ~full;

    // Burst is normalised on capture: writes are single-beat and a zero burst means one beat.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            full      <= 1'b0;
            cmd_wr    <= 1'b0;
            cmd_addr  <= '0;
            cmd_din   <= '0;
            cmd_be    <= '0;
            cmd_burst <= '0;
        end else begin
            if (free) begin
                full <= 1'b0;
            end else if (accept) begin
                full <= 1'b1;
            end
            if (accept) begin
                cmd_wr    <= we;
                cmd_addr  <= addr;
                cmd_din   <= din;
                cmd_be    <= be;
                cmd_burst <= (we || burst == '0) ? BW'(1) : burst;
            end
        end
    end

endmodule

// File: rtl/mem_toggle_arbiter.sv
// Round-robin arbiter from NPORT command slots onto one toggle-handshake memory backend,
// with a registered read-data return path.
module mem_toggle_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NPORT = DEF_NPORT,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int BW    = DEF_BW
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NPORT-1:0]           p_rd,
    input  logic [NPORT-1:0]           p_we,
    input  logic [NPORT-1:0][AW-1:0]   p_addr,
    input  logic [NPORT-1:0][DW-1:0]   p_din,
    input  logic [NPORT-1:0][DW/8-1:0] p_be,
    input  logic [NPORT-1:0][BW-1:0]   p_burst,
    output logic [NPORT-1:0]           p_busy,
    output logic [DW-1:0]              p_dout,
    output logic [NPORT-1:0]           p_dout_ready,
    output logic                       req,
    output logic                       wr,
    output logic [AW-1:0]              addr,
    output logic [DW-1:0]              din,
    output logic [DW/8-1:0]            be,
    output logic [BW-1:0]              burst_cnt,
    input  logic                       ack,
    input  logic [DW-1:0]              dout,
    input  logic                       ready
);

    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    arb_state_t state, state_nxt;

    logic [PW-1:0] grant;
    logic [PW-1:0] pick;
    logic [PW-1:0] cand;
    logic          pick_valid;
    logic [BW-1:0] beat_cnt;
    logic          ack_match;
    logic          rd_active;
    logic          beat;
    logic          done;

    logic [NPORT-1:0]           slot_full;
    logic [NPORT-1:0]           slot_free;
    logic [NPORT-1:0]           slot_wr;
    logic [NPORT-1:0][AW-1:0]   slot_addr;
    logic [NPORT-1:0][DW-1:0]   slot_din;
    logic [NPORT-1:0][DW/8-1:0] slot_be;
    logic [NPORT-1:0][BW-1:0]   slot_burst;

    for (genvar i = 0; i < NPORT; i++) begin : g_slot
        mem_port_slot #(
            .AW(AW),
            .DW(DW),
            .BW(BW)
        ) u_slot (
            .clk      (clk),
            .resetn   (resetn),
            .rd       (p_rd[i]),
            .we       (p_we[i]),
            .addr     (p_addr[i]),
            .din      (p_din[i]),
            .be       (p_be[i]),
            .burst    (p_burst[i]),
            .free     (slot_free[i]),
            .full     (slot_full[i]),
            .cmd_wr   (slot_wr[i]),
            .cmd_addr (slot_addr[i]),
            .cmd_din  (slot_din[i]),
            .cmd_be   (slot_be[i]),
            .cmd_burst(slot_burst[i])
        );
    end

    assign p_busy    = slot_full;
    assign ack_match = (ack == req);

    // Scan downwards so the nearest full slot after the last grant is the one that sticks.
    always_comb begin
        pick       = grant;
        pick_valid = 1'b0;
        cand       = '0;
        for (int k = NPORT; k >= 1; k--) begin
            cand = PW'((int'(grant) + k) % NPORT);
            if (slot_full[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (pick_valid) state_nxt = ISSUE;
            ISSUE:    state_nxt = WAIT_ACK;
            WAIT_ACK: if (ack_match) state_nxt = wr ? IDLE : RDATA;
            RDATA:    if (beat_cnt == burst_cnt) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Beats are accepted as soon as the request is out, since ready may beat the ack back.
    always_comb begin
        rd_active = ((state == WAIT_ACK) || (state == RDATA)) && !wr;
        beat      = rd_active && ready && (beat_cnt < burst_cnt);
        done      = ((state == WAIT_ACK) && ack_match && wr) ||
                    ((state == RDATA) && (beat_cnt == burst_cnt));
        slot_free = '0;
        if (done) begin
            slot_free[grant] = 1'b1;
        end
    end

    // grant doubles as the round-robin pointer; loading req from ack re-syncs the handshake.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            req          <= ack;
            grant        <= PW'(NPORT - 1);
            beat_cnt     <= '0;
            wr           <= 1'b0;
            addr         <= '0;
            din          <= '0;
            be           <= '0;
            burst_cnt    <= '0;
            p_dout       <= '0;
            p_dout_ready <= '0;
        end else begin
            p_dout_ready <= '0;
            if ((state == IDLE) && pick_valid) begin
                grant     <= pick;
                wr        <= slot_wr[pick];
                addr      <= slot_addr[pick];
                din       <= slot_din[pick];
                be        <= slot_be[pick];
                burst_cnt <= slot_burst[pick];
            end
            if (state == ISSUE) begin
                req      <= ~req;
                beat_cnt <= '0;
            end
            if (beat) begin
                beat_cnt            <= beat_cnt + BW'(1);
                p_dout              <= dout;
                p_dout_ready[grant] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_toggle_arbiter.sv
// Directed and randomised bench for mem_toggle_arbiter against a slot/round-robin reference model.
module tb_mem_toggle_arbiter;

    localparam int NPORT = 4;
    localparam int AW    = 25;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int BEW   = DW / 8;

    logic                      clk = 1'b0;
    logic                      resetn = 1'b0;
    logic [NPORT-1:0]          p_rd = '0;
    logic [NPORT-1:0]          p_we = '0;
    logic [NPORT-1:0][AW-1:0]  p_addr = '0;
    logic [NPORT-1:0][DW-1:0]  p_din = '0;
    logic [NPORT-1:0][BEW-1:0] p_be = '0;
    logic [NPORT-1:0][BW-1:0]  p_burst = '0;
    logic [NPORT-1:0]          p_busy;
    logic [DW-1:0]             p_dout;
    logic [NPORT-1:0]          p_dout_ready;
    logic                      req;
    logic                      wr;
    logic [AW-1:0]             addr;
    logic [DW-1:0]             din;
    logic [BEW-1:0]            be;
    logic [BW-1:0]             burst_cnt;
    logic                      ack = 1'b0;
    logic [DW-1:0]             dout = '0;
    logic                      ready = 1'b0;

    mem_toggle_arbiter #(.NPORT(NPORT), .AW(AW), .DW(DW), .BW(BW)) dut (
        .clk(clk), .resetn(resetn),
        .p_rd(p_rd), .p_we(p_we), .p_addr(p_addr), .p_din(p_din), .p_be(p_be), .p_burst(p_burst),
        .p_busy(p_busy), .p_dout(p_dout), .p_dout_ready(p_dout_ready),
        .req(req), .wr(wr), .addr(addr), .din(din), .be(be), .burst_cnt(burst_cnt),
        .ack(ack), .dout(dout), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit             valid;
        bit             wr;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  din;
        logic [BEW-1:0] be;
        int             burst;
    } cmd_t;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
    } beat_t;

    int            n_checks = 0;
    int            n_fail = 0;
    int            toggles = 0;
    logic          prev_req;
    beat_t         beats[$];
    cmd_t          model_slot[NPORT];
    int            model_last = NPORT - 1;
    logic [DW-1:0] none[$];
    logic [DW-1:0] t1_data[$];

    // Backend-side observer: counts req toggles outside reset and logs every returned beat.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_req = req;
        end else begin
            if (req !== prev_req) toggles++;
            prev_req = req;
        end
        if (p_dout_ready != '0) begin
            beat_t b;
            b.port = -1;
            if ($onehot(p_dout_ready)) begin
                for (int i = 0; i < NPORT; i++) if (p_dout_ready[i]) b.port = i;
            end
            b.data = p_dout;
            beats.push_back(b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one port's command lines (no clock) and record it in the model.
    task automatic applyStimulus(input int port, input bit rd, input bit we, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input logic [BEW-1:0] b, input logic [BW-1:0] bu);
        p_rd[port]    = rd;
        p_we[port]    = we;
        p_addr[port]  = a;
        p_din[port]   = d;
        p_be[port]    = b;
        p_burst[port] = bu;
        if (rd || we) begin
            model_slot[port].valid = 1'b1;
            model_slot[port].wr    = we;
            model_slot[port].addr  = a;
            model_slot[port].din   = d;
            model_slot[port].be    = b;
            model_slot[port].burst = we ? 1 : ((int'(bu) == 0) ? 1 : int'(bu));
        end
    endtask

    function automatic int model_next();
        for (int k = 1; k <= NPORT; k++) begin
            int q;
            q = (model_last + k) % NPORT;
            if (model_slot[q].valid) begin
                model_last = q;
                return q;
            end
        end
        return -1;
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        p_rd   = '0;
        p_we   = '0;
        ready  = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        for (int i = 0; i < NPORT; i++) model_slot[i].valid = 1'b0;
        model_last = NPORT - 1;
    endtask

    task automatic check_reset_state(input string tag);
        checkOutput({tag, "_busy"}, 64'(p_busy), 64'(0));
        checkOutput({tag, "_dout_ready"}, 64'(p_dout_ready), 64'(0));
        checkOutput({tag, "_p_dout"}, 64'(p_dout), 64'(0));
        checkOutput({tag, "_wr"}, 64'(wr), 64'(0));
        checkOutput({tag, "_addr"}, 64'(addr), 64'(0));
        checkOutput({tag, "_din"}, 64'(din), 64'(0));
        checkOutput({tag, "_be"}, 64'(be), 64'(0));
        checkOutput({tag, "_burst_cnt"}, 64'(burst_cnt), 64'(0));
        checkOutput({tag, "_req_eq_ack"}, 64'(req), 64'(ack));
    endtask

    task automatic pulse_ready(input logic [DW-1:0] data);
        ready = 1'b1;
        dout  = data;
        tick();
        ready = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 40 && req === ack; i++) tick();
        checkOutput("req_pending", 64'(req !== ack), 64'(1));
    endtask

    task automatic wait_free(input int p);
        for (int i = 0; i < 40 && p_busy[p]; i++) tick();
        checkOutput($sformatf("p%0d_slot_freed", p), 64'(p_busy[p]), 64'(0));
    endtask

    task automatic deliver(input int p, input logic [DW-1:0] data, input bit last);
        if (last) checkOutput($sformatf("p%0d_busy_before_last", p), 64'(p_busy[p]), 64'(1));
        pulse_ready(data);
    endtask

    // Act as the backend for the next transaction the model expects, then score it.
    task automatic serve(input int early, input bit extra, input bit rearm, input logic [DW-1:0] fixed[$]);
        int p, n, e, tg0;
        cmd_t c;
        logic [DW-1:0] dq[$];
        p = model_next();
        if (p < 0) return;
        c = model_slot[p];
        tg0 = toggles;
        beats.delete();
        wait_req();
        checkOutput($sformatf("p%0d_addr", p), 64'(addr), 64'(c.addr));
        checkOutput($sformatf("p%0d_wr", p), 64'(wr), 64'(c.wr));
        checkOutput($sformatf("p%0d_burst_cnt", p), 64'(burst_cnt), 64'(c.burst));
        if (c.wr) begin
            checkOutput($sformatf("p%0d_din", p), 64'(din), 64'(c.din));
            checkOutput($sformatf("p%0d_be", p), 64'(be), 64'(c.be));
        end
        n = c.wr ? 0 : c.burst;
        for (int i = 0; i < n; i++) dq.push_back((i < fixed.size()) ? fixed[i] : DW'($urandom()));
        e = (early < 0) ? $urandom_range(0, n) : ((early > n) ? n : early);
        for (int i = 0; i < e; i++) deliver(p, dq[i], i == n - 1);
        if (extra && e == n && n > 0) pulse_ready(DW'($urandom()));
        repeat ($urandom_range(0, 2)) tick();
        if (c.wr) checkOutput($sformatf("p%0d_busy_before_ack", p), 64'(p_busy[p]), 64'(1));
        ack = req;
        for (int i = e; i < n; i++) begin
            repeat ($urandom_range(0, 1)) tick();
            deliver(p, dq[i], i == n - 1);
        end
        wait_free(p);
        model_slot[p].valid = rearm;
        checkOutput($sformatf("p%0d_req_toggles", p), 64'(toggles - tg0), 64'(1));
        checkOutput($sformatf("p%0d_nbeats", p), 64'(beats.size()), 64'(n));
        for (int i = 0; i < n && i < beats.size(); i++) begin
            checkOutput($sformatf("p%0d_beat%0d_port", p, i), 64'(beats[i].port), 64'(p));
            checkOutput($sformatf("p%0d_beat%0d_data", p, i), 64'(beats[i].data), 64'(dq[i]));
        end
    endtask

    initial begin
        int tg, p;
        logic [NPORT-1:0] mask;

        do_reset();
        check_reset_state("reset0");

        // Single read, port 0, burst 4 with fixed data A0..A3
        for (int i = 0; i < 4; i++) t1_data.push_back(DW'(32'hA0 + i));
        applyStimulus(0, 1'b1, 1'b0, AW'(25'h100), '0, '0, BW'(4));
        tick();
        p_rd = '0;
        checkOutput("t1_accept_busy0", 64'(p_busy[0]), 64'(1));
        serve(0, 1'b0, 1'b0, t1_data);

        // Write, port 1: burst forced to 1, exactly one toggle
        applyStimulus(1, 1'b0, 1'b1, AW'(25'h2000), 32'hDEADBEEF, 4'hC, BW'(7));
        tick();
        p_we = '0;
        serve(0, 1'b0, 1'b0, none);
        tg = toggles;
        repeat (5) tick();
        checkOutput("t2_no_phantom_toggle", 64'(toggles - tg), 64'(0));

        // Early data: both beats (and a spare) arrive before the ack match
        applyStimulus(2, 1'b1, 1'b0, AW'($urandom()), '0, '0, BW'(2));
        tick();
        p_rd = '0;
        serve(2, 1'b1, 1'b0, none);

        // Burst zero behaves as one beat; stray ready afterwards is ignored
        applyStimulus(0, 1'b1, 1'b0, AW'($urandom()), '0, '0, BW'(0));
        tick();
        p_rd = '0;
        serve(0, 1'b0, 1'b0, none);
        beats.delete();
        pulse_ready(DW'($urandom()));
        repeat (3) tick();
        checkOutput("t4_stray_ready", 64'(beats.size()), 64'(0));

        // Fairness: all four ports hold single-beat reads for 12 transactions
        ack = 1'($urandom_range(0, 1));
        do_reset();
        check_reset_state("reset1");
        for (int i = 0; i < NPORT; i++) applyStimulus(i, 1'b1, 1'b0, AW'(32'h40 * i + 32'h1000), '0, '0, BW'(1));
        tick();
        for (int t = 0; t < 12; t++) begin
            serve(-1, 1'b0, t != 11, none);
            if (t == 11) p_rd = '0;
        end
        for (int t = 0; t < NPORT - 1; t++) serve(-1, 1'b0, 1'b0, none);
        checkOutput("t5_all_idle", 64'(p_busy), 64'(0));

        // Randomised rounds: a random set of ports issue together, then drain in round-robin order
        for (int r = 0; r < 20; r++) begin
            mask = NPORT'($urandom_range(1, (1 << NPORT) - 1));
            for (int i = 0; i < NPORT; i++) begin
                if (mask[i]) begin
                    bit rd_b, we_b;
                    rd_b = 1'($urandom_range(0, 1));
                    we_b = rd_b ? 1'($urandom_range(0, 1)) : 1'b1;
                    applyStimulus(i, rd_b, we_b, AW'($urandom()), DW'($urandom()),
                                  BEW'($urandom()), BW'($urandom_range(0, 15)));
                end
            end
            tick();
            p_rd = '0;
            p_we = '0;
            checkOutput($sformatf("rnd%0d_accept", r), 64'(p_busy), 64'(mask));
            for (int i = 0; i < $countones(mask); i++) serve(-1, 1'($urandom_range(0, 1)), 1'b0, none);
        end

        // Reset in the middle of a read: handshake re-syncs and late beats are dropped
        applyStimulus(2, 1'b1, 1'b0, AW'(25'h0ABCD), '0, '0, BW'(4));
        tick();
        p_rd = '0;
        p = model_next();
        beats.delete();
        wait_req();
        checkOutput("t7_addr", 64'(addr), 64'(25'h0ABCD));
        ack = req;
        tick();
        pulse_ready(DW'($urandom()));
        pulse_ready(DW'($urandom()));
        tick();
        checkOutput("t7_beats_before_reset", 64'(beats.size()), 64'(2));
        checkOutput("t7_busy_before_reset", 64'(p_busy[p]), 64'(1));
        ack = ~req;
        do_reset();
        check_reset_state("reset2");
        tg = toggles;
        beats.delete();
        pulse_ready(DW'($urandom()));
        tick();
        pulse_ready(DW'($urandom()));
        repeat (4) tick();
        checkOutput("t7_no_toggle", 64'(toggles - tg), 64'(0));
        checkOutput("t7_late_beats", 64'(beats.size()), 64'(0));
        checkOutput("t7_req_eq_ack", 64'(req), 64'(ack));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_toggle_arbiter.md
MEM_TOGGLE_ARBITER -- requirements
Module: mem_toggle_arbiter

Interface
REQ-001 SHALL have parameter NPORT, default 2, number of CPU-side ports (1..8).
REQ-002 SHALL have parameter AW, default 25, word-address width.
REQ-003 SHALL have parameter DW, default 32, data width; byte-enable width is DW/8.
REQ-004 SHALL have parameter BW, default 4, burst-count width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-007 SHALL have per-port input vectors p_rd[NPORT], p_we[NPORT], p_addr[NPORT][AW], p_din[NPORT][DW], p_be[NPORT][DW/8] and p_burst[NPORT][BW], carrying the command.
REQ-008 SHALL have per-port outputs p_busy[NPORT], p_dout[DW] (shared) and p_dout_ready[NPORT], giving accept stall and read data strobe.
REQ-009 SHALL have backend outputs req (1), wr (1), addr (AW), din (DW), be (DW/8) and burst_cnt (BW).
REQ-010 SHALL have backend inputs ack (1), dout (DW) and ready (1); req/ack use toggle protocol, and a request is pending while req != ack.

Function
REQ-011 SHALL accept port i's command on a cycle with (p_rd[i] | p_we[i]) & ~p_busy[i], latching it into port i's one-entry slot.
REQ-012 SHALL assert p_busy[i] while slot i is full; the slot frees in the cycle its transaction completes.
REQ-013 SHALL treat p_we & p_rd together as a write.
REQ-014 SHALL treat burst value 0 as 1.
REQ-015 SHALL force burst to 1 for writes, since writes are single-beat.
REQ-016 SHALL use states IDLE, ISSUE, WAIT_ACK, RDATA.
REQ-017 IDLE: SHALL select the next full slot round-robin, starting after the last granted port, and go to ISSUE; with no full slot it stays in IDLE.
REQ-018 ISSUE: SHALL drive wr/addr/din/be/burst_cnt from the granted slot, toggle req (registered), and go to WAIT_ACK.
REQ-019 SHALL hold wr/addr/din/be/burst_cnt stable from ISSUE until the transaction completes.
REQ-020 WAIT_ACK: when ack == req, a write SHALL complete (slot freed, go to IDLE) and a read SHALL go to RDATA.
REQ-021 SHALL count read beats in any state after ISSUE, including WAIT_ACK, because ready may precede the ack match.
REQ-022 For each ready pulse, SHALL present p_dout = dout and pulse p_dout_ready[granted] one cycle later (1-cycle registered latency).
REQ-023 RDATA: after the last beat (count == burst) SHALL free the slot and go to IDLE.
REQ-024 SHALL ignore ready while no read is outstanding.
REQ-025 SHALL count extra ready pulses beyond burst as neither data nor errors.
REQ-026 If a port issues a new command in the same cycle its slot frees, SHALL not accept it; it is accepted next cycle (p_busy is registered).
REQ-027 SHALL achieve back-to-back throughput of one transaction start per 2 cycles after completion (IDLE→ISSUE).
REQ-028 With all slots full, each port SHALL be granted once per NPORT transactions.

Reset
REQ-029 While resetn=0, SHALL set all slots empty, state IDLE, round-robin pointer to port NPORT-1 (so port 0 wins first), and beat counter to 0.
REQ-030 While resetn=0, SHALL set p_busy=0, p_dout_ready=0, p_dout=0, wr=0, addr=0, din=0, be=0, burst_cnt=0.
REQ-031 On reset, SHALL load req from the current ack value, so no phantom request is issued and toggle sync is recovered when reset lands mid-transaction.
REQ-032 SHALL abandon any in-flight transaction on reset; late ready/ack from it are ignored per REQ-024.

Structure
REQ-033 SHALL place the state enum and the default parameter constants in shared package mem_arb_pkg.
REQ-034 SHALL implement the per-port one-entry command latch and busy logic as sub-module mem_port_slot, instantiated NPORT times.
REQ-035 SHALL keep the arbiter FSM, round-robin pointer, beat counter and data return path in the top module.

Verification
REQ-036 Single read: port0 rd addr=0x100, burst=4; backend acks, then 4 ready with data 0xA0..0xA3 -> p_dout_ready[0] pulses 4 times with those values, p_busy[0] drops after the 4th beat, and p_dout_ready[1] stays 0.
REQ-037 Write: port1 we addr=0x2000, din=0xDEADBEEF, be=0xC, burst=7 -> backend sees wr=1, burst_cnt=1, be=0xC, and exactly one req toggle; slot freed on ack match.
REQ-038 Fairness: with NPORT=4, all four ports hold continuous reads (burst=1) -> grant order 0,1,2,3,0,1,... over 12 transactions, with no port starved.
REQ-039 Reset mid-read: resetn low during RDATA after 2 of 4 beats, backend ack differing from req -> after reset req == ack, no req toggle occurs, and 2 late ready pulses produce no p_dout_ready.
REQ-040 Early data: ready beats arrive before ack matches (burst=2) -> both beats delivered and transaction completes on ack match.
REQ-041 Burst zero: port0 rd burst=0 -> burst_cnt=1 and the transaction completes after 1 beat.
